// File: rtl/mac_pin_driver.sv
// Host-side initiator for the MAC tile pin interface: drives operands, waits a
// fixed latency, captures result bytes from the tile and returns them on a response channel.
module mac_pin_driver #(
  parameter int LAT       = 2,
  parameter int RES_BYTES = 1,
  parameter int CLR_CYC   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_op,
  input  logic [7:0]             cmd_a,
  input  logic [7:0]             cmd_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [8*RES_BYTES-1:0] rsp_data,
  output logic [7:0]             pin_a,
  output logic [7:0]             pin_b,
  input  logic [7:0]             pin_uo,
  output logic                   pin_ena,
  output logic                   pin_rst_n,
  output logic                   busy,
  output logic [15:0]            op_count
);

  localparam int DW = 8 * RES_BYTES;
  localparam int LW = (LAT > 1) ? $clog2(LAT) : 1;
  localparam int BW = (RES_BYTES > 1) ? $clog2(RES_BYTES) : 1;
  localparam int CW = (CLR_CYC > 1) ? $clog2(CLR_CYC) : 1;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_READ, S_RESP, S_CLEAR} state_t;

  state_t          state_q, state_d;
  logic [LW-1:0]   lat_q, lat_d;
  logic [BW-1:0]   byte_q, byte_d;
  logic [CW-1:0]   clr_q, clr_d;
  logic [7:0]      pin_a_q, pin_a_d;
  logic [7:0]      pin_b_q, pin_b_d;
  logic            pin_ena_q, pin_ena_d;
  logic            pin_rst_n_q, pin_rst_n_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]   rsp_data_q, rsp_data_d;
  logic [15:0]     op_count_q, op_count_d;
  logic            is_mac_q, is_mac_d;
  logic            accept;

  // pin_ena_q is low only until the first edge out of reset, so it also gates acceptance.
  assign cmd_ready = (state_q == S_IDLE) && pin_ena_q;
  assign accept    = cmd_valid && cmd_ready;

  always_comb begin
    state_d     = state_q;
    lat_d       = lat_q;
    byte_d      = byte_q;
    clr_d       = clr_q;
    pin_a_d     = pin_a_q;
    pin_b_d     = pin_b_q;
    pin_ena_d   = 1'b1;
    pin_rst_n_d = 1'b1;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    op_count_d  = op_count_q;
    is_mac_d    = is_mac_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          lat_d    = LW'(LAT - 1);
          byte_d   = '0;
          clr_d    = CW'(CLR_CYC - 1);
          is_mac_d = (cmd_op == 2'b00);
          case (cmd_op)
            2'b00: begin
              pin_a_d = cmd_a;
              pin_b_d = cmd_b;
              state_d = S_WAIT;
            end
            2'b01: state_d = S_READ;
            2'b10: begin
              pin_rst_n_d = 1'b0;
              state_d     = S_CLEAR;
            end
            default: state_d = S_IDLE;
          endcase
        end
      end

      S_WAIT: begin
        if (lat_q != '0) begin
          lat_d = lat_q - LW'(1);
        end else begin
          // Latency elapsed: one result byte per edge, lowest byte first.
          for (int i = 0; i < RES_BYTES; i++) begin
            if (byte_q == BW'(i)) rsp_data_d[8*i +: 8] = pin_uo;
          end
          if (byte_q == BW'(RES_BYTES - 1)) begin
            rsp_valid_d = 1'b1;
            state_d     = S_RESP;
          end else begin
            byte_d = byte_q + BW'(1);
          end
        end
      end

      S_READ: begin
        rsp_data_d  = DW'(pin_uo);
        rsp_valid_d = 1'b1;
        state_d     = S_RESP;
      end

      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
          if (is_mac_q && op_count_q != 16'hFFFF) op_count_d = op_count_q + 16'd1;
        end
      end

      S_CLEAR: begin
        if (clr_q == '0) begin
          state_d = S_IDLE;
        end else begin
          clr_d       = clr_q - CW'(1);
          pin_rst_n_d = 1'b0;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      lat_q       <= '0;
      byte_q      <= '0;
      clr_q       <= '0;
      pin_a_q     <= '0;
      pin_b_q     <= '0;
      pin_ena_q   <= 1'b0;
      pin_rst_n_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      op_count_q  <= '0;
      is_mac_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      lat_q       <= lat_d;
      byte_q      <= byte_d;
      clr_q       <= clr_d;
      pin_a_q     <= pin_a_d;
      pin_b_q     <= pin_b_d;
      pin_ena_q   <= pin_ena_d;
      pin_rst_n_q <= pin_rst_n_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      op_count_q  <= op_count_d;
      is_mac_q    <= is_mac_d;
    end
  end

  assign pin_a     = pin_a_q;
  assign pin_b     = pin_b_q;
  assign pin_ena   = pin_ena_q;
  assign pin_rst_n = pin_rst_n_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign op_count  = op_count_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_mac_pin_driver.sv
// Randomized bench for mac_pin_driver: transaction-level model of pins, response
// timing and op counting, checked at the falling edge after each rising edge.
module tb_mac_pin_driver;

  localparam int LAT = 2;
  localparam int RB  = 2;
  localparam int CLR = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready;
  logic [1:0]    cmd_op;
  logic [7:0]    cmd_a, cmd_b;
  logic          rsp_valid, rsp_ready;
  logic [8*RB-1:0] rsp_data;
  logic [7:0]    pin_a, pin_b, pin_uo;
  logic          pin_ena, pin_rst_n, busy;
  logic [15:0]   op_count;

  int errors = 0;
  int checks = 0;

  logic [7:0]  exp_a, exp_b;
  logic [15:0] exp_cnt;

  always #5 clk = ~clk;

  mac_pin_driver #(.LAT(LAT), .RES_BYTES(RB), .CLR_CYC(CLR)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .pin_a(pin_a), .pin_b(pin_b), .pin_uo(pin_uo),
    .pin_ena(pin_ena), .pin_rst_n(pin_rst_n),
    .busy(busy), .op_count(op_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_pins(input string tag);
    chk({tag, "_pin_a"}, pin_a, exp_a);
    chk({tag, "_pin_b"}, pin_b, exp_b);
    chk({tag, "_ena"}, pin_ena, 1);
  endtask

  // Random command-side traffic that must be ignored while not ready.
  task automatic junk_cmd();
    cmd_valid = 1'($urandom);
    cmd_op    = 2'($urandom);
    cmd_a     = 8'($urandom);
    cmd_b     = 8'($urandom);
  endtask

  task automatic issue(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    chk("ready_before_accept", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    pin_uo    = 8'($urandom);
    @(negedge clk);
  endtask

  task automatic finish_rsp(input logic [8*RB-1:0] exp_d, input int stall, input bit mac);
    for (int s = 0; s < stall; s++) begin
      rsp_ready = 1'b0;
      junk_cmd();
      pin_uo = 8'($urandom);
      @(negedge clk);
      chk("stall_valid", rsp_valid, 1);
      chk("stall_data", rsp_data, exp_d);
      chk("stall_ready", cmd_ready, 0);
      chk_pins("stall");
    end
    rsp_ready = 1'b1;
    junk_cmd();
    @(negedge clk);
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    if (mac && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
    chk("hs_valid_low", rsp_valid, 0);
    chk("hs_ready", cmd_ready, 1);
    chk("hs_busy", busy, 0);
    chk("hs_op_count", op_count, exp_cnt);
    chk_pins("hs");
    $display("rsp  mac=%0d data=%0h op_count=%0d stall=%0d", mac, exp_d, op_count, stall);
  endtask

  task automatic do_mac(input logic [7:0] a, input logic [7:0] b, input int stall);
    logic [8*RB-1:0] exp_d;
    logic [7:0] r;
    exp_d = '0;
    issue(2'b00, a, b);
    exp_a = a;
    exp_b = b;
    chk_pins("mac_accept");
    chk("mac_busy", busy, 1);
    chk("mac_ready_low", cmd_ready, 0);
    // Byte i is whatever the tile presents at edge E0+LAT+i.
    for (int k = 1; k <= LAT + RB - 1; k++) begin
      chk("mac_early_valid", rsp_valid, 0);
      r = 8'($urandom);
      pin_uo = r;
      if (k >= LAT) exp_d[8*(k-LAT) +: 8] = r;
      junk_cmd();
      rsp_ready = 1'($urandom);
      @(negedge clk);
      chk_pins("mac_wait");
    end
    chk("mac_valid", rsp_valid, 1);
    chk("mac_data", rsp_data, exp_d);
    $display("mac  a=%02h b=%02h", a, b);
    finish_rsp(exp_d, stall, 1'b1);
  endtask

  task automatic do_read(input int stall);
    logic [7:0] r;
    issue(2'b01, 8'($urandom), 8'($urandom));
    chk_pins("read_accept");
    chk("read_busy", busy, 1);
    r = 8'($urandom);
    pin_uo = r;
    junk_cmd();
    @(negedge clk);
    chk("read_valid", rsp_valid, 1);
    chk("read_data", rsp_data, {{(8*RB-8){1'b0}}, r});
    $display("read uo=%02h", r);
    finish_rsp({{(8*RB-8){1'b0}}, r}, stall, 1'b0);
  endtask

  task automatic do_clear();
    issue(2'b10, 8'($urandom), 8'($urandom));
    chk("clr_rst_n_low", pin_rst_n, 0);
    chk("clr_busy", busy, 1);
    chk("clr_ready_low", cmd_ready, 0);
    for (int j = 1; j < CLR; j++) begin
      junk_cmd();
      @(negedge clk);
      chk("clr_hold_low", pin_rst_n, 0);
      chk("clr_no_rsp", rsp_valid, 0);
    end
    junk_cmd();
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("clr_rst_n_high", pin_rst_n, 1);
    chk("clr_ready", cmd_ready, 1);
    chk("clr_busy_low", busy, 0);
    chk("clr_no_rsp_end", rsp_valid, 0);
    chk("clr_op_count", op_count, exp_cnt);
    chk_pins("clr");
    $display("clear done");
  endtask

  task automatic do_nop(input int n);
    chk("ready_before_nop", cmd_ready, 1);
    for (int j = 0; j < n; j++) begin
      cmd_valid = 1'b1;
      cmd_op    = 2'b11;
      cmd_a     = 8'($urandom);
      cmd_b     = 8'($urandom);
      @(negedge clk);
      chk("nop_ready", cmd_ready, 1);
      chk("nop_busy", busy, 0);
      chk("nop_no_rsp", rsp_valid, 0);
      chk_pins("nop");
    end
    cmd_valid = 1'b0;
    $display("nop  x%0d", n);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_pin_a"}, pin_a, 0);
    chk({tag, "_pin_b"}, pin_b, 0);
    chk({tag, "_rst_n"}, pin_rst_n, 0);
    chk({tag, "_ena"}, pin_ena, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_data"}, rsp_data, 0);
    chk({tag, "_op_count"}, op_count, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_cmd_ready"}, cmd_ready, 0);
  endtask

  task automatic release_reset();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ena", pin_ena, 1);
    chk("post_rst_rst_n", pin_rst_n, 1);
    chk("post_rst_ready", cmd_ready, 1);
    chk("post_rst_busy", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_op = 2'b11; cmd_a = '0; cmd_b = '0;
    rsp_ready = 1'b0; pin_uo = '0;
    exp_a = '0; exp_b = '0; exp_cnt = '0;

    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    release_reset();

    do_mac(8'h03, 8'h05, 0);
    do_mac(8'h03, 8'h05, 5);
    do_clear();
    do_mac(8'hFF, 8'hFF, 0);
    do_read(0);
    do_nop(3);

    // Reset while a MAC is waiting on the tile: no response may survive it.
    issue(2'b00, 8'hA5, 8'h3C);
    junk_cmd();
    @(negedge clk);
    rst = 1'b1;
    cmd_valid = 1'b0;
    #1;
    exp_a = '0; exp_b = '0; exp_cnt = '0;
    chk_reset_outputs("midop_rst");
    @(negedge clk);
    release_reset();
    for (int j = 0; j < 4; j++) begin
      rsp_ready = 1'($urandom);
      @(negedge clk);
      chk("no_stale_rsp", rsp_valid, 0);
    end
    rsp_ready = 1'b0;
    $display("reset mid-op recovered");
    do_mac(8'h11, 8'h22, 1);

    for (int t = 0; t < 80; t++) begin
      case ($urandom_range(0, 3))
        0, 1: do_mac(8'($urandom), 8'($urandom), int'($urandom_range(0, 4)));
        2: begin
          if ($urandom_range(0, 1) == 0) do_read(int'($urandom_range(0, 3)));
          else do_clear();
        end
        default: do_nop(int'($urandom_range(1, 3)));
      endcase
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
